// File: rtl/ka_pkg.sv
// -----------------------------------------------------------------------------
// ka_pkg
// Shared definitions for the ka_4bit Karatsuba multiplier leaf.
//   KA_W     : operand width (4)
//   KA_HALF  : half-operand width (2)
//   KA_PW    : product width (8)
//   ka_prod_t: full-width unsigned product
//   ka_part_t: the three Karatsuba partial products handed from the
//              partial-product stage to the recombination stage
//   ka_recombine(): y = (z2<<4) + ((z1-z2-z0)<<2) + z0
// -----------------------------------------------------------------------------
package ka_pkg;

    localparam int KA_W    = 4;
    localparam int KA_HALF = 2;
    localparam int KA_PW   = 8;

    typedef logic [KA_PW-1:0] ka_prod_t;

    typedef struct packed {
        logic [3:0] z0;   // aL*bL, max 9
        logic [3:0] z2;   // aH*bH, max 9
        logic [5:0] z1;   // (aH+aL)*(bH+bL), max 36
    } ka_part_t;

    // The middle term z1-z2-z0 equals aH*bL + aL*bH, so it cannot go
    // negative (max 18) and a 6-bit unsigned subtraction is exact. The
    // shifted terms sum to at most 225, so the 8-bit add cannot overflow.
    function automatic ka_prod_t ka_recombine(input ka_part_t p);
        logic [5:0] mid;
        mid = p.z1 - {2'b00, p.z2} - {2'b00, p.z0};
        return {p.z2, 4'b0000} + {mid, 2'b00} + {4'b0000, p.z0};
    endfunction

endpackage

// File: rtl/ka_mul3.sv
// -----------------------------------------------------------------------------
// ka_mul3
// Combinational unsigned 3x3 -> 6-bit multiplier used for the three
// Karatsuba partial products.
// Ports:
//   x : 3-bit unsigned operand
//   y : 3-bit unsigned operand
//   p : 6-bit unsigned product x*y
// -----------------------------------------------------------------------------
module ka_mul3 (
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic [5:0] p
);

    // Widen both operands first so the multiply is evaluated at 6 bits.
    assign p = {3'b000, x} * {3'b000, y};

endmodule

// File: rtl/ka_4bit.sv
// -----------------------------------------------------------------------------
// ka_4bit
// Unsigned 4x4 -> 8-bit Karatsuba multiplier with a streaming valid flag.
// Three narrow partial products (z0, z2, z1) are formed from the 2-bit
// halves and recombined into the full product.
//
// Configuration macro: KA_4BIT_PIPE_EN
//   defined   : partial products registered, then output registered
//               (latency 2)
//   undefined : partial products feed recombination combinationally,
//               only the output register remains (latency 1)
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : a/b are sampled this cycle
//   a, b      : 4-bit unsigned operands
//   out_valid : y holds a valid product
//   y         : 8-bit unsigned product a*b
// -----------------------------------------------------------------------------
module ka_4bit
    import ka_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    output logic [7:0] y
);

    // ---------------------------------------------------------------
    // Partial products
    // ---------------------------------------------------------------
    logic [2:0] sa, sb;
    logic [5:0] z0_full, z2_full, z1_full;
    logic [3:0] unused_hi;
    ka_part_t   part_comb;

    assign sa = {1'b0, a[3:2]} + {1'b0, a[1:0]};
    assign sb = {1'b0, b[3:2]} + {1'b0, b[1:0]};

    ka_mul3 u_z0 (.x({1'b0, a[1:0]}), .y({1'b0, b[1:0]}), .p(z0_full));
    ka_mul3 u_z2 (.x({1'b0, a[3:2]}), .y({1'b0, b[3:2]}), .p(z2_full));
    ka_mul3 u_z1 (.x(sa),             .y(sb),             .p(z1_full));

    // 2-bit x 2-bit products never exceed 9, so the top bits are always 0.
    assign unused_hi = {z0_full[5:4], z2_full[5:4]};

    assign part_comb = '{z0: z0_full[3:0], z2: z2_full[3:0], z1: z1_full};

    // ---------------------------------------------------------------
    // Optional partial-product register stage
    // ---------------------------------------------------------------
    logic     st_valid;
    ka_part_t st_part;

`ifdef KA_4BIT_PIPE_EN
    logic     s1_valid_q, s1_valid_d;
    ka_part_t s1_part_q,  s1_part_d;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        s1_valid_d = in_valid;
        s1_part_d  = s1_part_q;
        if (in_valid) begin
            s1_part_d = part_comb;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values, independent of block order.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_part_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_part_q  <= s1_part_d;
        end
    end

    assign st_valid = s1_valid_q;
    assign st_part  = s1_part_q;
`else
    assign st_valid = in_valid;
    assign st_part  = part_comb;
`endif

    // ---------------------------------------------------------------
    // Recombination and output register
    // ---------------------------------------------------------------
    logic     out_valid_q, out_valid_d;
    ka_prod_t y_q,         y_d;

    always_comb begin
        out_valid_d = st_valid;
        y_d         = y_q;          // hold the last product while idle
        if (st_valid) begin
            y_d = ka_recombine(st_part);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, so y reads 0 after reset
        // rather than a stale product from before it.
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_ka_4bit.sv
// -----------------------------------------------------------------------------
// tb_ka_4bit
// Self-checking bench for ka_4bit. The reference model treats the block as
// an ideal delay line of LAT cycles carrying {valid, a*b}; y follows the
// last valid product and both clear on reset.
// -----------------------------------------------------------------------------
module tb_ka_4bit;

`ifdef KA_4BIT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [7:0] y;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         mdl_v [LAT];
    logic [7:0] mdl_p [LAT];
    bit         exp_v;
    logic [7:0] exp_y;

    ka_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare 1 time unit later.
    task automatic step(input bit iv, input logic [3:0] av, input logic [3:0] bv,
                        input bit r, input string tag);
        int prod;
        @(negedge clk);
        in_valid = iv;
        a        = av;
        b        = bv;
        rst      = r;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < LAT; i++) begin
                mdl_v[i] = 1'b0;
                mdl_p[i] = 8'd0;
            end
            exp_v = 1'b0;
            exp_y = 8'd0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                mdl_v[i] = mdl_v[i-1];
                mdl_p[i] = mdl_p[i-1];
            end
            prod     = int'(av) * int'(bv);
            mdl_v[0] = iv;
            mdl_p[0] = prod[7:0];
            exp_v    = mdl_v[LAT-1];
            if (exp_v) exp_y = mdl_p[LAT-1];
        end
        check({tag, "_valid"}, {7'd0, out_valid}, {7'd0, exp_v});
        check({tag, "_y"}, y, exp_y);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 4'($urandom), 1'b0, tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        exp_v    = 1'b0;
        exp_y    = 8'd0;
        for (int i = 0; i < LAT; i++) begin
            mdl_v[i] = 1'b0;
            mdl_p[i] = 8'd0;
        end

        // Reset state
        step(1'b1, 4'd7, 4'd7, 1'b1, "reset");
        step(1'b0, 4'd0, 4'd0, 1'b1, "reset");
        check("reset_y_zero", y, 8'd0);

        // 13*10 = 130: bit 7 must survive
        step(1'b1, 4'd13, 4'd10, 1'b0, "d13x10");
        idle(LAT - 1, "d13x10_wait");
        check("d13x10_valid_const", {7'd0, out_valid}, 8'd1);
        check("d13x10_const", y, 8'd130);
        idle(2, "d13x10_hold");
        check("d13x10_hold_const", y, 8'd130);

        // Boundaries: max product, zero operand, unit operand
        step(1'b1, 4'd15, 4'd15, 1'b0, "d15x15");
        idle(LAT - 1, "d15x15_wait");
        check("d15x15_const", y, 8'd225);
        step(1'b1, 4'd0, 4'd9, 1'b0, "d0x9");
        idle(LAT - 1, "d0x9_wait");
        check("d0x9_const", y, 8'd0);
        step(1'b1, 4'd1, 4'd7, 1'b0, "d1x7");
        idle(LAT - 1, "d1x7_wait");
        check("d1x7_const", y, 8'd7);
        idle(2, "drain1");

        // in_valid toggling 1,0,1
        step(1'b1, 4'd3, 4'd5, 1'b0, "tog_a");
        step(1'b0, 4'($urandom), 4'($urandom), 1'b0, "tog_b");
        step(1'b1, 4'd6, 4'd6, 1'b0, "tog_c");
        idle(LAT - 1, "tog_wait");
        check("tog_last_const", y, 8'd36);
        idle(2, "drain2");

        // Reset with two operations in flight
        step(1'b1, 4'd9, 4'd9, 1'b0, "rf_in0");
        step(1'b1, 4'd11, 4'd12, 1'b0, "rf_in1");
        step(1'b1, 4'd14, 4'd14, 1'b1, "rf_rst");
        check("rf_rst_y_const", y, 8'd0);
        check("rf_rst_valid_const", {7'd0, out_valid}, 8'd0);
        idle(LAT + 1, "rf_quiet");
        step(1'b1, 4'd5, 4'd6, 1'b0, "rf_post");
        idle(LAT - 1, "rf_post_wait");
        check("rf_post_const", y, 8'd30);
        idle(2, "drain3");

        // Exhaustive back-to-back stream
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 4'(i >> 4), 4'(i), 1'b0, "exh");
        end
        idle(LAT, "exh_drain");

        // Randomized traffic with sparse valids and occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 4'($urandom), 4'($urandom),
                 ($urandom % 60) == 0, "rnd");
        end
        idle(LAT, "rnd_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
